// File: rtl/psk_demod_if.sv
// AXI-Stream beat channel carrying decided PSK symbols toward the receive FIFO.
interface psk_demod_if #(
  parameter int unsigned BYTES = 1
) ();
  logic [BYTES*8-1:0] tdata;
  logic               tvalid;
  logic               tready;
  logic               tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/psk_demod.sv
// Coherent BPSK/QPSK integrate-and-dump demodulator: sums SPS samples per rail,
// hard-decides the sign and emits one symbol per AXIS beat from a holding register.
module psk_demod #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned BYTES = 1,
  parameter int unsigned SPS   = 16
) (
  input  logic                     clk_16M384,
  input  logic                     rst_16M384,
  input  logic                     is_bpsk,
  input  logic signed [WIDTH-1:0]  in_I,
  input  logic signed [WIDTH-1:0]  in_Q,
  input  logic                     in_vld,
  input  logic                     in_last,
  psk_demod_if.master              data,
  output logic                     overflow,
  output logic [$clog2(SPS)-1:0]   sym_cnt
);
  localparam int unsigned CntW = $clog2(SPS);
  localparam int unsigned AccW = WIDTH + CntW;

  typedef enum logic [0:0] {StIdle, StInteg} state_e;

  state_e                 state_q, state_d;
  logic signed [AccW-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic signed [AccW-1:0] ext_i, ext_q, sum_i, sum_q;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   bpsk_q, bpsk_d, mode;
  logic                   done, fire, dec_i, dec_q;
  logic                   tvalid_q, tvalid_d, tlast_q, tlast_d, ovf_q, ovf_d;
  logic [BYTES*8-1:0]     tdata_q, tdata_d;

  assign ext_i = {{CntW{in_I[WIDTH-1]}}, in_I};
  assign ext_q = {{CntW{in_Q[WIDTH-1]}}, in_Q};
  assign sum_i = acc_i_q + ext_i;
  assign sum_q = acc_q_q + ext_q;

  // Mode is taken live on the first sample of a symbol, latched afterwards.
  assign mode  = (cnt_q == '0) ? is_bpsk : bpsk_q;
  assign done  = in_vld && (in_last || (cnt_q == CntW'(SPS - 1)));
  assign dec_i = ~sum_i[AccW-1];
  assign dec_q = mode ? 1'b0 : ~sum_q[AccW-1];
  assign fire  = tvalid_q && data.tready;

  always_comb begin
    state_d = state_q;
    acc_i_d = acc_i_q;
    acc_q_d = acc_q_q;
    cnt_d   = cnt_q;
    bpsk_d  = bpsk_q;
    if (in_vld) begin
      acc_i_d = sum_i;
      acc_q_d = sum_q;
      cnt_d   = cnt_q + CntW'(1);
      bpsk_d  = mode;
      unique case (state_q)
        StIdle:  state_d = in_last ? StIdle : StInteg;
        StInteg: state_d = in_last ? StIdle : StInteg;
        default: state_d = StIdle;
      endcase
      if (done) begin
        acc_i_d = '0;
        acc_q_d = '0;
        cnt_d   = '0;
      end
    end
  end

  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    ovf_d    = ovf_q;
    if (fire) begin
      tvalid_d = 1'b0;
    end
    if (done) begin
      // A completion on the transfer edge refills the register without a bubble.
      if (!tvalid_q || fire) begin
        tvalid_d   = 1'b1;
        tdata_d    = '0;
        tdata_d[1] = dec_i;
        tdata_d[0] = dec_q;
        tlast_d    = in_last;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
    if (rst_16M384) begin
      state_q  <= StIdle;
      acc_i_q  <= '0;
      acc_q_q  <= '0;
      cnt_q    <= '0;
      bpsk_q   <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_i_q  <= acc_i_d;
      acc_q_q  <= acc_q_d;
      cnt_q    <= cnt_d;
      bpsk_q   <= bpsk_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      ovf_q    <= ovf_d;
    end
  end

  assign data.tvalid = tvalid_q;
  assign data.tdata  = tdata_q;
  assign data.tlast  = tlast_q;
  assign overflow    = ovf_q;
  assign sym_cnt     = cnt_q;
endmodule

// File: tb/tb_psk_demod.sv
// Self-checking bench for psk_demod: directed scenarios plus random bursts against
// an integer-sum reference model of the integrate-and-dump decision.
module tb_psk_demod;
  localparam int SPS = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               is_bpsk = 1'b0;
  logic signed [11:0] in_I = '0;
  logic signed [11:0] in_Q = '0;
  logic               in_vld = 1'b0;
  logic               in_last = 1'b0;
  logic               overflow;
  logic [3:0]         sym_cnt;

  psk_demod_if #(.BYTES(1)) data_if ();

  psk_demod #(.WIDTH(12), .BYTES(1), .SPS(SPS)) dut (
    .clk_16M384 (clk),
    .rst_16M384 (rst),
    .is_bpsk    (is_bpsk),
    .in_I       (in_I),
    .in_Q       (in_Q),
    .in_vld     (in_vld),
    .in_last    (in_last),
    .data       (data_if.master),
    .overflow   (overflow),
    .sym_cnt    (sym_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];

  int m_si, m_sq, m_n;
  bit m_bpsk;

  // Beats are logged half a cycle before the edge that transfers them.
  always @(negedge clk) begin
    if (!rst && data_if.tvalid && data_if.tready)
      got_q.push_back({data_if.tlast, data_if.tdata});
  end

  task automatic model_clear();
    m_si = 0; m_sq = 0; m_n = 0; m_bpsk = 1'b0;
  endtask

  task automatic model_push(input int i, input int q, input bit last, input bit bpsk);
    bit di, dq;
    if (m_n == 0) m_bpsk = bpsk;
    m_si += i;
    m_sq += q;
    m_n++;
    if (m_n == SPS || last) begin
      di = (m_si >= 0);
      dq = m_bpsk ? 1'b0 : (m_sq >= 0);
      exp_q.push_back({last, 6'b0, di, dq});
      model_clear();
    end
  endtask

  task automatic send(input int i, input int q, input bit last);
    in_I = 12'(i);
    in_Q = 12'(q);
    in_vld = 1'b1;
    in_last = last;
    model_push(i, q, last, is_bpsk);
    @(posedge clk); #1;
    in_vld = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic idle(input int n);
    in_vld = 1'b0;
    in_last = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    in_vld = 1'b0;
    in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    exp_q.delete();
    got_q.delete();
    @(posedge clk); #1;
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  task automatic test_reset();
    data_if.tready = 1'b1;
    rst = 1'b1;
    #2;
    n_checks++;
    if (data_if.tvalid !== 1'b0) begin n_errors++; $display("FAIL reset_tvalid got=%b want=0", data_if.tvalid); end
    n_checks++;
    if (data_if.tdata !== 8'h00) begin n_errors++; $display("FAIL reset_tdata got=%h want=00", data_if.tdata); end
    n_checks++;
    if (data_if.tlast !== 1'b0) begin n_errors++; $display("FAIL reset_tlast got=%b want=0", data_if.tlast); end
    n_checks++;
    if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    n_checks++;
    if (sym_cnt !== 4'd0) begin n_errors++; $display("FAIL reset_sym_cnt got=%0d want=0", sym_cnt); end
    apply_reset();
  endtask

  task automatic test_bpsk();
    int sgn[4] = '{1, -1, -1, 1};
    apply_reset();
    data_if.tready = 1'b1;
    is_bpsk = 1'b1;
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < SPS; k++) begin
        send(sgn[s] * 1000, rnd_sample(), (s == 3) && (k == SPS - 1));
        if (s == 1 && k == 4) begin
          n_checks++;
          if (sym_cnt !== 4'(m_n)) begin n_errors++; $display("FAIL bpsk_sym_cnt got=%0d want=%0d", sym_cnt, m_n); end
        end
      end
    end
    idle(3);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_errors++; $display("FAIL bpsk_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[k] !== exp_q[k]) begin n_errors++; $display("FAIL bpsk_beat%0d got=%h want=%h", k, got_q[k], exp_q[k]); end
    end
    n_checks++;
    if (overflow !== 1'b0) begin n_errors++; $display("FAIL bpsk_overflow got=%b want=0", overflow); end
  endtask

  task automatic test_qpsk();
    apply_reset();
    data_if.tready = 1'b1;
    is_bpsk = 1'b0;
    for (int k = 0; k < SPS; k++) send(500, -500, 1'b0);
    n_checks++;
    if (data_if.tvalid !== 1'b1 || {data_if.tlast, data_if.tdata} !== exp_q[0]) begin
      n_errors++;
      $display("FAIL qpsk_latency1 got=%b/%h want=1/%h", data_if.tvalid, {data_if.tlast, data_if.tdata}, exp_q[0]);
    end
    send(-300, 300, 1'b0);
    n_checks++;
    if (data_if.tvalid !== 1'b0) begin n_errors++; $display("FAIL qpsk_drop_valid got=%b want=0", data_if.tvalid); end
    for (int k = 1; k < SPS; k++) send(-300, 300, k == SPS - 1);
    n_checks++;
    if (data_if.tvalid !== 1'b1 || {data_if.tlast, data_if.tdata} !== exp_q[1]) begin
      n_errors++;
      $display("FAIL qpsk_latency2 got=%b/%h want=1/%h", data_if.tvalid, {data_if.tlast, data_if.tdata}, exp_q[1]);
    end
    idle(3);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_errors++; $display("FAIL qpsk_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[k] !== exp_q[k]) begin n_errors++; $display("FAIL qpsk_beat%0d got=%h want=%h", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] held;
    apply_reset();
    data_if.tready = 1'b0;
    is_bpsk = 1'b0;
    for (int k = 0; k < SPS; k++) send(700, 700, 1'b0);
    held = {data_if.tlast, data_if.tdata};
    n_checks++;
    if (data_if.tvalid !== 1'b1 || held !== exp_q[0]) begin
      n_errors++; $display("FAIL bp_first got=%b/%h want=1/%h", data_if.tvalid, held, exp_q[0]);
    end
    for (int k = 0; k < SPS; k++) send(-700, 700, 1'b0);
    n_checks++;
    if ({data_if.tlast, data_if.tdata} !== exp_q[0] || data_if.tvalid !== 1'b1) begin
      n_errors++; $display("FAIL bp_held got=%h want=%h", {data_if.tlast, data_if.tdata}, exp_q[0]);
    end
    n_checks++;
    if (overflow !== 1'b1) begin n_errors++; $display("FAIL bp_overflow_set got=%b want=1", overflow); end
    data_if.tready = 1'b1;
    for (int k = 0; k < SPS; k++) send(700, -700, k == SPS - 1);
    idle(3);
    n_checks++;
    if (got_q.size() != 2) begin n_errors++; $display("FAIL bp_count got=%0d want=2", got_q.size()); end
    if (got_q.size() == 2 && exp_q.size() == 3) begin
      n_checks++;
      if (got_q[0] !== exp_q[0]) begin n_errors++; $display("FAIL bp_beat0 got=%h want=%h", got_q[0], exp_q[0]); end
      n_checks++;
      if (got_q[1] !== exp_q[2]) begin n_errors++; $display("FAIL bp_beat1 got=%h want=%h", got_q[1], exp_q[2]); end
    end
    n_checks++;
    if (overflow !== 1'b1) begin n_errors++; $display("FAIL bp_overflow_sticky got=%b want=1", overflow); end
  endtask

  task automatic test_gaps_partial();
    int si[SPS], sq[SPS];
    logic [8:0] ref_beat;
    apply_reset();
    data_if.tready = 1'b1;
    is_bpsk = 1'b0;
    for (int k = 0; k < SPS; k++) begin si[k] = rnd_sample(); sq[k] = rnd_sample(); end
    for (int k = 0; k < SPS; k++) send(si[k], sq[k], k == SPS - 1);
    idle(3);
    ref_beat = (got_q.size() > 0) ? got_q[0] : 9'h1ff;
    n_checks++;
    if (got_q.size() != 1 || ref_beat !== exp_q[0]) begin
      n_errors++; $display("FAIL gap_ref got=%h (n=%0d) want=%h", ref_beat, got_q.size(), exp_q[0]);
    end
    got_q.delete();
    exp_q.delete();
    for (int k = 0; k < SPS; k++) begin
      if (k == 8) begin
        idle(5);
        n_checks++;
        if (sym_cnt !== 4'(m_n)) begin n_errors++; $display("FAIL gap_hold_cnt got=%0d want=%0d", sym_cnt, m_n); end
      end
      send(si[k], sq[k], k == SPS - 1);
    end
    idle(3);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== ref_beat) begin
      n_errors++; $display("FAIL gap_same got=%h (n=%0d) want=%h", (got_q.size() > 0) ? got_q[0] : 9'h1ff, got_q.size(), ref_beat);
    end
    got_q.delete();
    exp_q.delete();
    for (int k = 0; k < 20; k++) send(rnd_sample(), rnd_sample(), k == 19);
    idle(3);
    n_checks++;
    if (got_q.size() != 2) begin n_errors++; $display("FAIL partial_count got=%0d want=2", got_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[k] !== exp_q[k]) begin n_errors++; $display("FAIL partial_beat%0d got=%h want=%h", k, got_q[k], exp_q[k]); end
    end
    if (got_q.size() == 2) begin
      n_checks++;
      if (got_q[1][8] !== 1'b1) begin n_errors++; $display("FAIL partial_tlast got=%b want=1", got_q[1][8]); end
    end
  endtask

  task automatic test_tie_wrap();
    apply_reset();
    data_if.tready = 1'b1;
    is_bpsk = 1'b0;
    for (int k = 0; k < SPS; k++) send((k % 2) ? -100 : 100, (k % 2) ? 5 : -5, k == SPS - 1);
    for (int k = 0; k < SPS; k++) send(-2048, -2048, k == SPS - 1);
    idle(3);
    n_checks++;
    if (got_q.size() != 2) begin n_errors++; $display("FAIL tie_count got=%0d want=2", got_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[k] !== exp_q[k]) begin n_errors++; $display("FAIL tie_beat%0d got=%h want=%h", k, got_q[k], exp_q[k]); end
    end
    n_checks++;
    if (overflow !== 1'b0) begin n_errors++; $display("FAIL wrap_overflow got=%b want=0", overflow); end
  endtask

  task automatic test_random();
    int len;
    apply_reset();
    data_if.tready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      len = $urandom_range(1, 70);
      for (int k = 0; k < len; k++) begin
        is_bpsk = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        send(rnd_sample(), rnd_sample(), k == len - 1);
      end
      idle($urandom_range(0, 4));
    end
    idle(3);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_errors++; $display("FAIL rand_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[k] !== exp_q[k]) begin n_errors++; $display("FAIL rand_beat%0d got=%h want=%h", k, got_q[k], exp_q[k]); end
    end
    n_checks++;
    if (overflow !== 1'b0) begin n_errors++; $display("FAIL rand_overflow got=%b want=0", overflow); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    data_if.tready = 1'b0;
    is_bpsk = 1'b0;
    for (int k = 0; k < SPS; k++) send(400, -400, 1'b0);
    for (int k = 0; k < 6; k++) send(400, 400, 1'b0);
    in_I = 12'sd400;
    in_Q = 12'sd400;
    in_vld = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({data_if.tvalid, data_if.tlast, data_if.tdata} !== 10'h0) begin
      n_errors++; $display("FAIL midrst_axis got=%h want=000", {data_if.tvalid, data_if.tlast, data_if.tdata});
    end
    n_checks++;
    if (overflow !== 1'b0 || sym_cnt !== 4'd0) begin
      n_errors++; $display("FAIL midrst_state got=%b/%0d want=0/0", overflow, sym_cnt);
    end
    in_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    exp_q.delete();
    got_q.delete();
    data_if.tready = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < SPS; k++) send(-600, 600, k == SPS - 1);
    idle(3);
    n_checks++;
    if (got_q.size() != 1) begin n_errors++; $display("FAIL midrst_count got=%0d want=1", got_q.size()); end
    if (got_q.size() > 0 && exp_q.size() > 0) begin
      n_checks++;
      if (got_q[0] !== exp_q[0]) begin n_errors++; $display("FAIL midrst_beat got=%h want=%h", got_q[0], exp_q[0]); end
    end
  endtask

  initial begin
    data_if.tready = 1'b1;
    model_clear();
    test_reset();
    test_bpsk();
    test_qpsk();
    test_gaps_partial();
    test_tie_wrap();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
